// File: rtl/gate_pkg.sv
// Shared types for the gate arbiter: opcode enum and default datapath width.
package gate_pkg;
  typedef enum logic [1:0] {OP_INV, OP_AND2, OP_NAND2, OP_OR2} gate_op_t;
  localparam int GATE_WIDTH = 64;
endpackage

// File: rtl/gate_unit_arbiter_if.sv
// Request/response bundle between the requesters and the gate arbiter.
interface gate_unit_arbiter_if
  import gate_pkg::*;
#(
  parameter int WIDTH = GATE_WIDTH,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic     [NREQ-1:0]            req_valid;
  logic     [NREQ-1:0]            req_ready;
  gate_op_t [NREQ-1:0]            req_op;
  logic     [NREQ-1:0][WIDTH-1:0] req_a;
  logic     [NREQ-1:0][WIDTH-1:0] req_b;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic     [WIDTH-1:0]           rsp_data;
  logic     [IDW-1:0]             rsp_id;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/gate_alu.sv
// Combinational gate datapath: every op is composed from Inv/And2 primitives.
module gate_alu
  import gate_pkg::*;
#(
  parameter int WIDTH = GATE_WIDTH
) (
  input  gate_op_t         op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] inv_a, inv_b, and_ab, nand_ab, and_nn, or_ab;

  Inv  #(.WIDTH(WIDTH)) u_inv_a  (.a(a),      .y(inv_a));
  Inv  #(.WIDTH(WIDTH)) u_inv_b  (.a(b),      .y(inv_b));
  And2 #(.WIDTH(WIDTH)) u_and    (.a(a),      .b(b),     .y(and_ab));
  Inv  #(.WIDTH(WIDTH)) u_nand   (.a(and_ab), .y(nand_ab));
  // De Morgan: a | b == ~(~a & ~b)
  And2 #(.WIDTH(WIDTH)) u_and_nn (.a(inv_a),  .b(inv_b), .y(and_nn));
  Inv  #(.WIDTH(WIDTH)) u_or     (.a(and_nn), .y(or_ab));

  always_comb begin
    y = inv_a;
    case (op)
      OP_INV:   y = inv_a;
      OP_AND2:  y = and_ab;
      OP_NAND2: y = nand_ab;
      OP_OR2:   y = or_ab;
      default:  y = inv_a;
    endcase
  end
endmodule

// File: rtl/gate_lib.sv
// Gate library primitives: bitwise inverter and 2-input AND.
module Inv #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = ~a;
endmodule

module And2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = a & b;
endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one gate_alu among NREQ requesters, with a
// registered, id-tagged result behind a valid/ready response port.
module gate_unit_arbiter
  import gate_pkg::*;
#(
  parameter int WIDTH = GATE_WIDTH,
  parameter int NREQ  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_unit_arbiter_if.slave bus
);
  localparam int             IDW      = $clog2(NREQ);
  localparam logic [IDW:0]   NREQ_W   = NREQ[IDW:0];
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic [IDW-1:0]   start, win;
  logic [IDW:0]     idx;
  logic             any_vld, can_accept, fire;
  logic [WIDTH-1:0] alu_y;

  assign start = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + 1'b1;

  // Rotate-by-(last_grant+1), priority-encode, rotate back: walk the
  // requesters starting at 'start' and take the first valid one.
  always_comb begin
    any_vld = 1'b0;
    win     = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, start} + (IDW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!any_vld && bus.req_valid[idx[IDW-1:0]]) begin
        any_vld = 1'b1;
        win     = idx[IDW-1:0];
      end
    end
  end

  assign can_accept = !rsp_valid_q || bus.rsp_ready;
  assign fire       = any_vld && can_accept;

  always_comb begin
    bus.req_ready = '0;
    if (fire) bus.req_ready[win] = 1'b1;
  end

  gate_alu #(.WIDTH(WIDTH)) u_alu (
    .op (bus.req_op[win]),
    .a  (bus.req_a[win]),
    .b  (bus.req_b[win]),
    .y  (alu_y)
  );

  // A new fire overwrites a draining result in place, so no bubble appears.
  always_comb begin
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    if (fire) begin
      last_grant_d = win;
      rsp_valid_d  = 1'b1;
      rsp_data_d   = alu_y;
      rsp_id_d     = win;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= LAST_IDX;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
endmodule
